// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Purpose  : Single-clock synchronous FIFO with a registered read port. Used
//            as a rate-smoothing buffer between a streaming source and sink.
// Ports    : wclk         - sole clock, all state changes on rising edge
//            wrst         - asynchronous active-low reset
//            wdata        - write data (DATA_WIDTH)
//            write_enable - write request, ignored while wfull
//            read_enable  - read request, ignored while rempty
//            rdata        - registered read data, holds when no read accepted
//            rempty       - FIFO holds zero words
//            wfull        - FIFO holds 2**ADDR_WIDTH words
//            wcount       - occupancy 0..2**ADDR_WIDTH (FIFO_COUNT_EN only)
// Options  : define FIFO_COUNT_EN to add the wcount occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
`ifdef FIFO_COUNT_EN
  output logic                  wfull,
  output logic [ADDR_WIDTH:0]   wcount
`else
  output logic                  wfull
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low address bits coincide.
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic w_write_accept;
  logic w_read_accept;

  // Flags come straight from registered pointers, so they are glitch-free.
  assign rempty = (r_wptr == r_rptr);
  assign wfull  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                  (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);

  // Gating uses the pre-edge flags: when full a read frees a slot only for
  // the following cycle, and when empty a write is not readable this cycle.
  assign w_write_accept = write_enable && !wfull;
  assign w_read_accept  = read_enable  && !rempty;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge wclk) begin
    if (w_write_accept) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_wptr <= '0;
    end else if (w_write_accept) begin
      r_wptr <= r_wptr + 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_rptr  <= '0;
      r_rdata <= '0;
    end else if (w_read_accept) begin
      r_rptr  <= r_rptr + 1'b1;
      r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign rdata = r_rdata;

`ifdef FIFO_COUNT_EN
  // Modular difference of the wrap-extended pointers yields 0..2**ADDR_WIDTH.
  assign wcount = r_wptr - r_rptr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo
// Purpose  : Self-checking bench for fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       write_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic [7:0] rdata;
  logic       rempty;
  logic       wfull;
`ifdef FIFO_COUNT_EN
  logic [4:0] wcount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of stored words plus the last word read.
  logic [7:0] q[$];
  logic [7:0] exp_rdata = 8'h00;

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .wdata        (wdata),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .rdata        (rdata),
    .rempty       (rempty),
`ifdef FIFO_COUNT_EN
    .wfull        (wfull),
    .wcount       (wcount)
`else
    .wfull        (wfull)
`endif
  );

  always #5 wclk = ~wclk;

  // Drive one cycle of stimulus and advance the model; returns #1 after edge.
  task automatic cycle(input logic we, input logic re, input logic [7:0] d);
    bit can_w;
    bit can_r;
    @(negedge wclk);
    write_enable = we;
    read_enable  = re;
    wdata        = d;
    @(posedge wclk);
    can_w = we && (q.size() < 16);
    can_r = re && (q.size() > 0);
    if (can_r) exp_rdata = q.pop_front();
    if (can_w) q.push_back(d);
    #1;
  endtask

  task automatic test_reset;
    wrst = 1'b0; write_enable = 1'b1; read_enable = 1'b1; wdata = 8'h55;
    q.delete(); exp_rdata = 8'h00;
    repeat (2) @(posedge wclk);
    #1;
    checks++;
    if ({rdata, rempty, wfull} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdata=%h rempty=%b wfull=%b, want 00 1 0", rdata, rempty, wfull);
    end
    // Release mid-cycle with a write pending; nothing may land before the edge.
    @(negedge wclk);
    read_enable = 1'b0; wdata = 8'h5A; wrst = 1'b1;
    #1;
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_no_write: got rempty=%b, want 1", rempty);
    end
    @(posedge wclk);
    q.push_back(8'h5A);
    #1;
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("FAIL first_write_after_release: got rempty=%b, want 0", rempty);
    end
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if ({rdata, rempty} !== {8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL first_read_after_release: got rdata=%h rempty=%b, want 5a 1", rdata, rempty);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      checks++;
      if ({rempty, wfull} !== {1'b0, (i >= 16)}) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got rempty=%b wfull=%b, want 0 %b", i, rempty, wfull, (i >= 16));
      end
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (wcount !== 5'd16) begin
      errors++;
      $display("FAIL fill_count: got %0d, want 16", wcount);
    end
`endif
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({rdata, rempty, wfull} !== {8'(i), (i == 16), 1'b0}) begin
        errors++;
        $display("FAIL drain[%0d]: got rdata=%h rempty=%b wfull=%b, want %h %b 0", i, rdata, rempty, wfull, 8'(i), (i == 16));
      end
    end
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if ({rdata, rempty} !== {8'h10, 1'b1}) begin
      errors++;
      $display("FAIL drain_extra_read: got rdata=%h rempty=%b, want 10 1", rdata, rempty);
    end
  endtask

  task automatic test_full_both;
    // Fill, then request both at once: read happens, write is dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    cycle(1'b1, 1'b1, 8'hEE);
    checks++;
    if ({rdata, wfull} !== {8'h80, 1'b0}) begin
      errors++;
      $display("FAIL full_both: got rdata=%h wfull=%b, want 80 0", rdata, wfull);
    end
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (rdata !== 8'(8'h80 + i)) begin
        errors++;
        $display("FAIL full_both_drain[%0d]: got %h, want %h", i, rdata, 8'(8'h80 + i));
      end
    end
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL full_both_dropped: got rempty=%b, want 1", rempty);
    end
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b1, 8'(i));
      checks++;
      if ({rdata, rempty, wfull} !== {((i >= 2) ? 8'(i - 1) : exp_rdata), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stream[%0d]: got rdata=%h rempty=%b wfull=%b, want %h 0 0", i, rdata, rempty, wfull, ((i >= 2) ? 8'(i - 1) : exp_rdata));
      end
`ifdef FIFO_COUNT_EN
      checks++;
      if (wcount !== 5'd1) begin
        errors++;
        $display("FAIL stream_count[%0d]: got %0d, want 1", i, wcount);
      end
`endif
    end
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if ({rdata, rempty} !== {8'd20, 1'b1}) begin
      errors++;
      $display("FAIL stream_tail: got rdata=%h rempty=%b, want 14 1", rdata, rempty);
    end
  endtask

  task automatic test_wrap;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        cycle(1'b1, 1'b0, 8'(8'h30 + r * 16 + i));
        checks++;
        if ({rempty, wfull} !== {1'b0, 1'b0}) begin
          errors++;
          $display("FAIL wrap_wr[%0d.%0d]: got rempty=%b wfull=%b, want 0 0", r, i, rempty, wfull);
        end
      end
      for (int i = 0; i < 10; i++) begin
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if ({rdata, rempty} !== {8'(8'h30 + r * 16 + i), (i == 9)}) begin
          errors++;
          $display("FAIL wrap_rd[%0d.%0d]: got rdata=%h rempty=%b, want %h %b", r, i, rdata, rempty, 8'(8'h30 + r * 16 + i), (i == 9));
        end
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      // Bias toward writes in the first half and reads in the second.
      cycle(($urandom_range(0, 99) < ((n < 200) ? 70 : 30)),
            ($urandom_range(0, 99) < ((n < 200) ? 30 : 70)),
            8'($urandom));
      checks++;
      if ({rdata, rempty, wfull} !== {exp_rdata, (q.size() == 0), (q.size() == 16)}) begin
        errors++;
        $display("FAIL random[%0d]: got rdata=%h rempty=%b wfull=%b, want %h %b %b", n, rdata, rempty, wfull, exp_rdata, (q.size() == 0), (q.size() == 16));
      end
`ifdef FIFO_COUNT_EN
      checks++;
      if (wcount !== 5'(q.size())) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d, want %0d", n, wcount, q.size());
      end
`endif
    end
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b0, 1'b1, 8'h00);
    @(negedge wclk);
    write_enable = 1'b0; read_enable = 1'b0;
    #2 wrst = 1'b0;
    q.delete(); exp_rdata = 8'h00;
    #1;
    checks++;
    if ({rdata, rempty, wfull} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got rdata=%h rempty=%b wfull=%b, want 00 1 0", rdata, rempty, wfull);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (wcount !== 5'd0) begin
      errors++;
      $display("FAIL async_reset_count: got %0d, want 0", wcount);
    end
`endif
    #1 wrst = 1'b1;
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if ({rdata, rempty} !== {8'hAA, 1'b1}) begin
      errors++;
      $display("FAIL after_async_reset: got rdata=%h rempty=%b, want aa 1", rdata, rempty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_both();
    test_streaming();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
